// File: rtl/motoro3_deadtime_guard.sv
// motoro3_deadtime_guard
// Gate-drive protection between the six raw bridge commands and the aH..cL pins.
// Each phase runs an identical IDLE/DRV_H/DRV_L/DEAD machine. The machine forces a full
// dead interval on every release of a driven side. Simultaneous H+L requests are blocked
// and latched as sticky per-phase faults. With FAULT_LATCH set, any latched fault turns
// every phase off until the fault is cleared.
module motoro3_deadtime_guard #(
  parameter int DEAD_CYC    = 20,
  parameter int CW          = 8,
  parameter bit FAULT_LATCH = 1'b1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en,
  input  logic       faultClr,
  input  logic       aH_i,
  input  logic       aL_i,
  input  logic       bH_i,
  input  logic       bL_i,
  input  logic       cH_i,
  input  logic       cL_i,
  output logic       aH,
  output logic       aL,
  output logic       bH,
  output logic       bL,
  output logic       cH,
  output logic       cL,
  output logic [2:0] fault,
  output logic       anyFault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRV_H = 2'd1,
    DRV_L = 2'd2,
    DEAD  = 2'd3
  } phaseState_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_H    = 2'd1,
    REQ_L    = 2'd2
  } req_e;

  // The counter is loaded with one less than the dead time because the
  // cycle on which it reaches zero is itself still spent in DEAD.
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYC - 1);

  logic [2:0]    rawH;
  logic [2:0]    rawL;
  logic [2:0]    conflict;
  logic          blockAll;
  req_e          req     [3];
  phaseState_e   state_q [3];
  phaseState_e   state_d [3];
  logic [CW-1:0] cnt_q   [3];
  logic [CW-1:0] cnt_d   [3];
  logic [2:0]    fault_q;
  logic [2:0]    fault_d;
  logic          anyFault_q;
  logic          anyFault_d;

  assign rawH     = {cH_i, bH_i, aH_i};
  assign rawL     = {cL_i, bL_i, aL_i};
  assign conflict = rawH & rawL;

  // Decode each phase's raw command pair into a single request. The request is NONE when drive is disabled or a latched fault is active.
  always_comb begin
    blockAll = ~en | (FAULT_LATCH & anyFault_q);
    for (int p = 0; p < 3; p++) begin
      req[p] = REQ_NONE;
      if (!blockAll) begin
        if (rawH[p] && !rawL[p]) begin
          req[p] = REQ_H;
        end else if (rawL[p] && !rawH[p]) begin
          req[p] = REQ_L;
        end
      end
    end
  end

  // Per-phase next-state and dead counter. Leaving a driven side always goes through DEAD with the full count.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      case (state_q[p])
        IDLE: begin
          if (req[p] == REQ_H) begin
            state_d[p] = DRV_H;
          end else if (req[p] == REQ_L) begin
            state_d[p] = DRV_L;
          end
        end
        DRV_H: begin
          if (req[p] != REQ_H) begin
            state_d[p] = DEAD;
            cnt_d[p]   = DEAD_LOAD;
          end
        end
        DRV_L: begin
          if (req[p] != REQ_L) begin
            state_d[p] = DEAD;
            cnt_d[p]   = DEAD_LOAD;
          end
        end
        DEAD: begin
          if (cnt_q[p] != '0) begin
            cnt_d[p] = cnt_q[p] - CW'(1);
          end else if (req[p] == REQ_H) begin
            state_d[p] = DRV_H;
          end else if (req[p] == REQ_L) begin
            state_d[p] = DRV_L;
          end else begin
            state_d[p] = IDLE;
          end
        end
        default: begin
          state_d[p] = IDLE;
          cnt_d[p]   = '0;
        end
      endcase
    end
  end

  // Phase state and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      for (int p = 0; p < 3; p++) begin
        state_q[p] <= IDLE;
        cnt_q[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  // Sticky fault flags. A new conflict beats a simultaneous clear. anyFault is registered from the same next value so it never lags fault.
  always_comb begin
    fault_d    = conflict | (fault_q & ~{3{faultClr}});
    anyFault_d = |fault_d;
  end

  // Fault registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      fault_q    <= '0;
      anyFault_q <= 1'b0;
    end else begin
      fault_q    <= fault_d;
      anyFault_q <= anyFault_d;
    end
  end

  assign aH       = (state_q[0] == DRV_H);
  assign aL       = (state_q[0] == DRV_L);
  assign bH       = (state_q[1] == DRV_H);
  assign bL       = (state_q[1] == DRV_L);
  assign cH       = (state_q[2] == DRV_H);
  assign cL       = (state_q[2] == DRV_L);
  assign fault    = fault_q;
  assign anyFault = anyFault_q;

endmodule

// File: tb/tb_motoro3_deadtime_guard.sv
// tb_motoro3_deadtime_guard
// Directed test of the dead-time guard at DEAD_CYC=20 with FAULT_LATCH=1.
module tb_motoro3_deadtime_guard;

  logic       clk = 1'b0;
  logic       nRst;
  logic       en;
  logic       faultClr;
  logic       aH_i, aL_i, bH_i, bL_i, cH_i, cL_i;
  logic       aH, aL, bH, bL, cH, cL;
  logic [2:0] fault;
  logic       anyFault;
  logic [5:0] gates;

  int compareCount  = 0;
  int mismatchCount = 0;
  int n;
  logic overlapSeen = 1'b0;

  motoro3_deadtime_guard #(
    .DEAD_CYC(20),
    .CW(8),
    .FAULT_LATCH(1'b1)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .en(en),
    .faultClr(faultClr),
    .aH_i(aH_i),
    .aL_i(aL_i),
    .bH_i(bH_i),
    .bL_i(bL_i),
    .cH_i(cH_i),
    .cL_i(cL_i),
    .aH(aH),
    .aL(aL),
    .bH(bH),
    .bL(bL),
    .cH(cH),
    .cL(cL),
    .fault(fault),
    .anyFault(anyFault)
  );

  // Gate drives packed as {aH,aL,bH,bL,cH,cL}. Bit 4 is aL, bit 3 is bH and bit 1 is cH.
  assign gates = {aH, aL, bH, bL, cH, cL};

  // 10 MHz clock
  always #50 clk = ~clk;

  // Record any cycle where one phase drives both sides at once.
  always @(negedge clk) begin
    if ((aH & aL) | (bH & bL) | (cH & cL)) overlapSeen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ah, input logic al, input logic bh, input logic bl,
                               input logic ch, input logic cl, input logic enV, input logic clrV);
    aH_i = ah; aL_i = al; bH_i = bh; bL_i = bl; cH_i = ch; cL_i = cl;
    en = enV; faultClr = clrV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Count the clock edges until the selected gate rises, giving up after 60.
  task automatic countToRise(input int bitIdx, output int cnt);
    cnt = 0;
    while (!gates[bitIdx] && cnt < 60) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    nRst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("rstGates", {26'd0, gates}, 32'd0);
    checkOutput("rstFault", {29'd0, fault}, 32'd0);
    checkOutput("rstAny", {31'd0, anyFault}, 32'd0);

    // Test 1: A high, then switch to low.
    nRst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t1aHLatency", {26'd0, gates}, 32'b100000);
    for (int i = 0; i < 49; i++) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t1aHFall", {26'd0, gates}, 32'd0);
    countToRise(4, n);
    checkOutput("t1DeadLen", n, 20);

    // Test 2: B and C drive high, then B gets a one-cycle conflict.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t2Drive", {26'd0, gates}, 32'b011010);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t2BOff", {26'd0, gates}, 32'b010010);
    checkOutput("t2Fault", {29'd0, fault}, 32'b010);
    checkOutput("t2Any", {31'd0, anyFault}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("t2AllOff", {26'd0, gates}, 32'd0);
    checkOutput("t2FaultHeld", {29'd0, fault}, 32'b010);
    tick(); tick(); tick();
    faultClr = 1'b1;
    tick();
    faultClr = 1'b0;
    checkOutput("t2Clr", {29'd0, fault}, 32'd0);
    checkOutput("t2ClrAny", {31'd0, anyFault}, 32'd0);
    countToRise(3, n);
    checkOutput("t2BResume", n, 15);
    checkOutput("t2OthersDead", {26'd0, gates}, 32'b001000);
    tick();
    checkOutput("t2OthersBack", {26'd0, gates}, 32'b011010);

    // Test 3: C drops for three cycles and then returns; the dead time stays at 20.
    cH_i = 1'b0;
    tick();
    checkOutput("t3cHOff", {31'd0, cH}, 32'd0);
    tick(); tick();
    cH_i = 1'b1;
    countToRise(1, n);
    checkOutput("t3FullDead", n, 18);

    // Test 4: en is dropped long enough to reach IDLE, then re-enabled.
    en = 1'b0;
    tick();
    checkOutput("t4EnOff", {26'd0, gates}, 32'd0);
    for (int i = 0; i < 24; i++) tick();
    en = 1'b1;
    tick();
    checkOutput("t4FromIdle", {26'd0, gates}, 32'b011010);
    // Test 4b: en is dropped for one edge only; the full dead time is still served.
    en = 1'b0;
    tick();
    en = 1'b1;
    checkOutput("t4bOff", {31'd0, aL}, 32'd0);
    countToRise(4, n);
    checkOutput("t4bDeadLen", n, 20);

    // Test 5: reset while C is partway through DEAD and A holds a fresh fault.
    cH_i = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) tick();
    aH_i = 1'b1;
    tick();
    checkOutput("t5PreFault", {29'd0, fault}, 32'b001);
    aH_i = 1'b0;
    cH_i = 1'b1;
    nRst = 1'b0;
    tick();
    checkOutput("t5RstGates", {26'd0, gates}, 32'd0);
    checkOutput("t5RstFault", {29'd0, fault}, 32'd0);
    checkOutput("t5RstAny", {31'd0, anyFault}, 32'd0);
    nRst = 1'b1;
    tick();
    checkOutput("t5Release", {26'd0, gates}, 32'b011010);

    // Test 6: clear arrives together with a new conflict on A.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("t6FaultBC", {29'd0, fault}, 32'b110);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("t6SetWins", {29'd0, fault}, 32'b001);
    checkOutput("t6Any", {31'd0, anyFault}, 32'd1);
    checkOutput("t6aLOff", {31'd0, aL}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();

    checkOutput("noOverlap", {31'd0, overlapSeen}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
